// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with early-out for divide-by-zero and signed overflow.
module riscv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            opcode_valid_i,
  input  logic [2:0]      opcode_op_i,
  input  logic [4:0]      opcode_rd_idx_i,
  input  logic [XLEN-1:0] opcode_ra_operand_i,
  input  logic [XLEN-1:0] opcode_rb_operand_i,
  input  logic            flush_i,
  output logic            writeback_valid_o,
  output logic [4:0]      writeback_idx_o,
  output logic [XLEN-1:0] writeback_value_o,
  output logic            stall_o
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [4:0]        rd_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, rneg_q;
  logic [2*XLEN-1:0] mcand_q, acc_q;
  logic [XLEN-1:0]   mplier_q, rem_q, quo_q, dvsr_q;

  logic accept;
  assign accept  = (state_q == S_IDLE) & opcode_valid_i & ~flush_i;
  assign stall_o = (state_q == S_MUL) | (state_q == S_DIV) | accept;

  // Operand decode at acceptance: signedness, magnitudes, early-out detection
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, early_val;
  always_comb begin
    is_div   = opcode_op_i[2];
    a_sgn    = is_div ? ~opcode_op_i[0] : (opcode_op_i[1:0] != 2'b11);
    b_sgn    = is_div ? ~opcode_op_i[0] : ~opcode_op_i[1];
    a_neg    = a_sgn & opcode_ra_operand_i[XLEN-1];
    b_neg    = b_sgn & opcode_rb_operand_i[XLEN-1];
    a_mag    = a_neg ? (~opcode_ra_operand_i + 1'b1) : opcode_ra_operand_i;
    b_mag    = b_neg ? (~opcode_rb_operand_i + 1'b1) : opcode_rb_operand_i;
    div_zero = (opcode_rb_operand_i == '0);
    div_ovf  = ~opcode_op_i[0] & (opcode_ra_operand_i == MIN_NEG) & (opcode_rb_operand_i == '1);
    if (div_zero) early_val = opcode_op_i[1] ? opcode_ra_operand_i : '1;
    else          early_val = opcode_op_i[1] ? '0 : MIN_NEG;
  end

  // One iteration step; on the last step the sign fix-up is folded into the result
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN:0]     rem_sh, diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, mul_res, div_res;
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod    = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvsr_q};
    q_bit   = ~diff[XLEN];
    rem_nxt = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], q_bit};
    if (op_q[1]) div_res = rneg_q ? (~rem_nxt + 1'b1) : rem_nxt;
    else         div_res = neg_q  ? (~quo_nxt + 1'b1) : quo_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q           <= S_IDLE;
      op_q              <= '0;
      rd_q              <= '0;
      cnt_q             <= '0;
      neg_q             <= 1'b0;
      rneg_q            <= 1'b0;
      mcand_q           <= '0;
      acc_q             <= '0;
      mplier_q          <= '0;
      rem_q             <= '0;
      quo_q             <= '0;
      dvsr_q            <= '0;
      writeback_valid_o <= 1'b0;
      writeback_idx_o   <= '0;
      writeback_value_o <= '0;
    end else begin
      writeback_valid_o <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q   <= opcode_op_i[1:0];
          rd_q   <= opcode_rd_idx_i;
          cnt_q  <= CW'(XLEN);
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          if (!is_div) begin
            mcand_q  <= {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            state_q  <= S_MUL;
          end else if (div_zero | div_ovf) begin
            writeback_valid_o <= 1'b1;
            writeback_idx_o   <= opcode_rd_idx_i;
            writeback_value_o <= early_val;
            state_q           <= S_DONE;
          end else begin
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvsr_q  <= b_mag;
            state_q <= S_DIV;
          end
        end
        S_MUL: if (flush_i) begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end else begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            writeback_valid_o <= 1'b1;
            writeback_idx_o   <= rd_q;
            writeback_value_o <= mul_res;
            state_q           <= S_DONE;
          end
        end
        S_DIV: if (flush_i) begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end else begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            writeback_valid_o <= 1'b1;
            writeback_idx_o   <= rd_q;
            writeback_value_o <= div_res;
            state_q           <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_muldiv.sv
// Bench for riscv_muldiv: spec vector table, random ops against a 64-bit arithmetic
// model, and hand sequences for flush, mid-op reset and the 16-bit width.
module tb_riscv_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, vld, flush, wb_vld, stall;
  logic [2:0]  op;
  logic [4:0]  rd, wb_idx;
  logic [31:0] ra, rb, wb_val;

  logic        vld16, wb_vld16, stall16;
  logic [2:0]  op16;
  logic [4:0]  wb_idx16;
  logic [15:0] ra16, rb16, wb_val16;

  riscv_muldiv #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .opcode_valid_i(vld), .opcode_op_i(op),
    .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb),
    .flush_i(flush), .writeback_valid_o(wb_vld), .writeback_idx_o(wb_idx),
    .writeback_value_o(wb_val), .stall_o(stall));

  riscv_muldiv #(.XLEN(16)) dut16 (
    .clk_i(clk), .rst_i(rst_n), .opcode_valid_i(vld16), .opcode_op_i(op16),
    .opcode_rd_idx_i(5'd3), .opcode_ra_operand_i(ra16), .opcode_rb_operand_i(rb16),
    .flush_i(1'b0), .writeback_valid_o(wb_vld16), .writeback_idx_o(wb_idx16),
    .writeback_value_o(wb_val16), .stall_o(stall16));

  int total = 0, bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] a, b, exp;
    int          lat;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic [2:0] o, logic [4:0] r, logic [31:0] a, logic [31:0] b,
                              logic [31:0] e, int l, string n);
    vec_t v;
    v.op = o; v.rd = r; v.a = a; v.b = b; v.exp = e; v.lat = l; v.nm = n;
    tbl.push_back(v);
  endfunction

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_res(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller enters mid-cycle (after a negedge); instruction is held until the pulse
  task automatic run_op(input logic [2:0] o, input logic [4:0] r, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int l, input string nm);
    int k;
    bit got, stall_ok, stall_at_pulse;
    op = o; rd = r; ra = a; rb = b; vld = 1'b1;
    #1 chk({nm, "/stall_T"}, 64'(stall), 64'd1);
    k = 0; got = 0; stall_ok = 1; stall_at_pulse = 1;
    while (!got && k < 100) begin
      @(negedge clk); k++;
      if (wb_vld) begin got = 1; stall_at_pulse = stall; end
      else if (!stall) stall_ok = 0;
    end
    vld = 1'b0;
    chk({nm, "/pulse"}, 64'(got), 64'd1);
    chk({nm, "/lat"}, 64'(k), 64'(l));
    chk({nm, "/value"}, 64'(wb_val), 64'(e));
    chk({nm, "/idx"}, 64'(wb_idx), 64'(r));
    chk({nm, "/stall_busy"}, 64'(stall_ok), 64'd1);
    chk({nm, "/stall_done"}, 64'(stall_at_pulse), 64'd0);
    @(negedge clk);
    chk({nm, "/after"}, {62'd0, wb_vld, stall}, 64'd0);
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e, input string nm);
    int k;
    bit got;
    op16 = o; ra16 = a; rb16 = b; vld16 = 1'b1;
    #1 chk({nm, "/stall_T"}, 64'(stall16), 64'd1);
    k = 0; got = 0;
    while (!got && k < 60) begin
      @(negedge clk); k++;
      if (wb_vld16) got = 1;
    end
    vld16 = 1'b0;
    chk({nm, "/pulse"}, 64'(got), 64'd1);
    chk({nm, "/lat"}, 64'(k), 64'd17);
    chk({nm, "/value"}, 64'(wb_val16), 64'(e));
    chk({nm, "/idx"}, 64'(wb_idx16), 64'd3);
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    logic [2:0]  ro;
    logic [31:0] a, b;
    rst_n = 1'b0; vld = 1'b0; flush = 1'b0; op = '0; rd = '0; ra = '0; rb = '0;
    vld16 = 1'b0; op16 = '0; ra16 = '0; rb16 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/wb_valid", 64'(wb_vld), 64'd0);
    chk("reset/wb_idx", 64'(wb_idx), 64'd0);
    chk("reset/wb_value", 64'(wb_val), 64'd0);
    chk("reset/stall", 64'(stall), 64'd0);
    chk("reset/wb16", {31'd0, wb_vld16, wb_val16, 16'd0}, 64'd0);
    rst_n = 1'b1;

    add(3'd0, 5'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    add(3'd1, 5'd2, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "mulh");
    add(3'd3, 5'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    add(3'd2, 5'd4, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, "mulhsu");
    add(3'd4, 5'd5, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div");
    add(3'd6, 5'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem");
    add(3'd5, 5'd7, 32'd100,        32'd7,         32'd14,        33, "divu");
    add(3'd7, 5'd8, 32'd100,        32'd7,         32'd2,         33, "remu");
    add(3'd5, 5'd9, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
    add(3'd6, 5'd10, 32'd5,         32'd0,         32'd5,         1,  "rem_by0");
    add(3'd4, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    add(3'd6, 5'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf_rd0");
    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].nm);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      run_op(ro, 5'($urandom_range(0, 31)), a, b, ref_res(ro, a, b), ref_lat(ro, a, b), "rand");
    end

    // Flush during a divide: no pulse, idle by T+11, new multiply accepted there
    op = 3'd4; rd = 5'd12; ra = 32'd1000; rb = 32'd3; vld = 1'b1;
    ok = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vld = 1'b0;
      if (wb_vld || !stall) ok = 0;
      if (k == 10) flush = 1'b1;
    end
    chk("flush/busy", 64'(ok), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush/idle_T11", {62'd0, wb_vld, stall}, 64'd0);
    run_op(3'd0, 5'd13, 32'd9, 32'd11, 32'd99, 33, "mul_after_flush");

    // Reset in the middle of an operation clears outputs and produces no pulse
    run_op(3'd0, 5'd14, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_pre_reset");
    op = 3'd4; rd = 5'd15; ra = 32'd1000; rb = 32'd3; vld = 1'b1;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    vld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset/outputs", {wb_vld, stall, wb_idx, wb_val}, 64'd0);
    ok = 1;
    repeat (40) begin
      @(negedge clk);
      if (wb_vld || stall) ok = 0;
    end
    chk("midreset/no_pulse", 64'(ok), 64'd1);

    run16(3'd0, 16'd7, 16'hFFFD, 16'hFFEB, "mul16");
    run16(3'd4, 16'hFFF9, 16'd2, 16'hFFFD, "div16");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
